// File: rtl/multichannel_hit_histogrammer.sv
// Per-channel hit histogrammer: NUM_CH channels, MEM_SIZE bins of BIN_CYCLES clocks each.
// Latency: a bin is written to memory on its last cycle; the first readout word is valid 1 cycle after READ entry.
// Backpressure: the readout stream holds out_data/out_ch/out_addr stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   mode, read        000 IDLE, 001 TAKE, 010 READ, 100 ZERO (others = IDLE); read strobes ZERO/READ
//   hit[NUM_CH]       synchronous hit inputs, one count per rising edge
//   out_*             valid/ready readout stream: bin count tagged with channel and bin address
//   busy, done        busy in ZERO/TAKE/READ, done in DONE (held until mode returns to 000)
//   ovf[NUM_CH]       sticky saturation flags, present only when HIST_OVERFLOW_FLAG_EN is defined
//
// Memory contents are not touched by rst; run ZERO after power-up.
module multichannel_hit_histogrammer #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_BITS  = 12,
    parameter int DATA_BITS  = 12,
    parameter int MEM_SIZE   = 64,
    parameter int BIN_CYCLES = 16,
    localparam int CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           mode,
    input  logic                 read,
    input  logic [NUM_CH-1:0]    hit,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] out_data,
    output logic [CH_BITS-1:0]   out_ch,
    output logic [ADDR_BITS-1:0] out_addr,
    output logic                 busy,
    output logic                 done
`ifdef HIST_OVERFLOW_FLAG_EN
   ,output logic [NUM_CH-1:0]    ovf
`endif
);

    localparam int MA = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int TW = (BIN_CYCLES > 1) ? $clog2(BIN_CYCLES) : 1;

    localparam logic [DATA_BITS-1:0] DATA_MAX  = {DATA_BITS{1'b1}};
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MEM_SIZE - 1);
    localparam logic [TW-1:0]        LAST_TIM  = TW'(BIN_CYCLES - 1);
    localparam logic [CH_BITS-1:0]   LAST_CH   = CH_BITS'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ZERO = 3'd1,
        S_TAKE = 3'd2,
        S_READ = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_BITS-1:0] addr_q;
    logic [TW-1:0]        tim_q;
    logic [NUM_CH-1:0]    hit_q;
    logic [DATA_BITS-1:0] acc_q [NUM_CH];
    logic [DATA_BITS-1:0] mem   [NUM_CH][MEM_SIZE];

    // Unrecognised mode encodings fall back to idle.
    logic mode_zero, mode_take, mode_read, mode_idle;
    assign mode_zero = (mode == 3'b100);
    assign mode_take = (mode == 3'b001);
    assign mode_read = (mode == 3'b010);
    assign mode_idle = !(mode_zero || mode_take || mode_read);

    logic [NUM_CH-1:0] hit_edge;
    assign hit_edge = hit & ~hit_q;

    logic bin_end;
    assign bin_end = (state_q == S_TAKE) && (tim_q == LAST_TIM);

    logic rd_fire, rd_last;
    assign rd_fire = out_valid && out_ready;
    assign rd_last = (out_ch == LAST_CH) && (out_addr == LAST_ADDR);

    logic enter_zero, enter_take, enter_read;
    assign enter_zero = (state_q == S_IDLE) && (state_d == S_ZERO);
    assign enter_take = (state_q == S_IDLE) && (state_d == S_TAKE);
    assign enter_read = (state_q == S_IDLE) && (state_d == S_READ);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Once out of IDLE only mode==000 can redirect the FSM, so switching
    // between non-zero modes mid-operation is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mode_zero && read) begin
                    state_d = S_ZERO;
                end else if (mode_take) begin
                    state_d = S_TAKE;
                end else if (mode_read && read) begin
                    state_d = S_READ;
                end
            end
            S_ZERO: begin
                if (mode_idle) begin
                    state_d = S_IDLE;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end
            end
            S_TAKE: begin
                if (mode_idle) begin
                    state_d = S_IDLE;
                end else if (bin_end && (addr_q == LAST_ADDR)) begin
                    state_d = S_DONE;
                end
            end
            S_READ: begin
                if (mode_idle) begin
                    state_d = S_IDLE;
                end else if (rd_fire && rd_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (mode_idle) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_ZERO) || (state_q == S_TAKE) || (state_q == S_READ);
    assign done = (state_q == S_DONE);

    // ------------------------------------------------------------------
    // Bin arithmetic
    // ------------------------------------------------------------------
    // One extra bit on the bin sum exposes the carry used for saturation.
    logic [DATA_BITS:0]   bin_sum [NUM_CH];
    logic [DATA_BITS-1:0] bin_val [NUM_CH];
    logic [DATA_BITS-1:0] acc_inc [NUM_CH];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            bin_sum[c] = {1'b0, mem[c][addr_q[MA-1:0]]} + {1'b0, acc_q[c]};
            bin_val[c] = bin_sum[c][DATA_BITS] ? DATA_MAX : bin_sum[c][DATA_BITS-1:0];
            acc_inc[c] = (hit_edge[c] && (acc_q[c] != DATA_MAX)) ? acc_q[c] + DATA_BITS'(1)
                                                                 : acc_q[c];
        end
    end

    // ------------------------------------------------------------------
    // Address, bin timer, accumulators, hit edge register
    // ------------------------------------------------------------------
    // Abort needs no special handling here: IDLE never uses these, and the
    // next ZERO/TAKE entry reinitialises them, dropping any partial bin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            tim_q  <= '0;
            hit_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            hit_q <= hit;
            if (enter_zero || enter_take) begin
                addr_q <= '0;
                tim_q  <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    acc_q[c] <= '0;
                end
            end else if (state_q == S_ZERO) begin
                addr_q <= addr_q + ADDR_BITS'(1);
            end else if (state_q == S_TAKE) begin
                if (bin_end) begin
                    // An edge on the bin-end cycle opens the next bin's count.
                    tim_q  <= '0;
                    addr_q <= addr_q + ADDR_BITS'(1);
                    for (int c = 0; c < NUM_CH; c++) begin
                        acc_q[c] <= DATA_BITS'(hit_edge[c]);
                    end
                end else begin
                    tim_q <= tim_q + TW'(1);
                    for (int c = 0; c < NUM_CH; c++) begin
                        acc_q[c] <= acc_inc[c];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Histogram memory: one write port shared by ZERO and TAKE, no reset.
    // A bin completing on an abort cycle is still written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (state_q == S_ZERO) begin
                mem[c][addr_q[MA-1:0]] <= '0;
            end else if (bin_end) begin
                mem[c][addr_q[MA-1:0]] <= bin_val[c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Readout stream
    // ------------------------------------------------------------------
    // out_ch/out_addr double as the traversal pointer. On a handshake the
    // next word is fetched immediately, so there are no bubbles.
    logic [CH_BITS-1:0]   nxt_ch;
    logic [ADDR_BITS-1:0] nxt_addr;

    always_comb begin
        nxt_ch   = out_ch + CH_BITS'(1);
        nxt_addr = out_addr;
        if (out_ch == LAST_CH) begin
            nxt_ch   = '0;
            nxt_addr = out_addr + ADDR_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_addr  <= '0;
        end else if (enter_read) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_addr  <= '0;
        end else if (state_q == S_READ) begin
            if (mode_idle) begin
                out_valid <= 1'b0;
            end else if (!out_valid) begin
                // First cycle after entry: present word (addr 0, ch 0).
                out_valid <= 1'b1;
                out_data  <= mem[out_ch][out_addr[MA-1:0]];
            end else if (out_ready) begin
                if (rd_last) begin
                    out_valid <= 1'b0;
                end else begin
                    out_ch   <= nxt_ch;
                    out_addr <= nxt_addr;
                    out_data <= mem[nxt_ch][nxt_addr[MA-1:0]];
                end
            end
        end
    end

`ifdef HIST_OVERFLOW_FLAG_EN
    // Sticky: set when an edge is lost to a full accumulator or when a bin
    // write clips; cleared only by rst or a new ZERO.
    logic [NUM_CH-1:0] ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
        end else if (enter_zero) begin
            ovf_q <= '0;
        end else if (state_q == S_TAKE) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bin_end && bin_sum[c][DATA_BITS]) begin
                    ovf_q[c] <= 1'b1;
                end else if (!bin_end && hit_edge[c] && (acc_q[c] == DATA_MAX)) begin
                    ovf_q[c] <= 1'b1;
                end
            end
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_multichannel_hit_histogrammer.sv
// Bench for multichannel_hit_histogrammer: directed vectors with hand-computed expectations.
// u_a uses default parameters; u_b (DATA_BITS=4, MEM_SIZE=4, BIN_CYCLES=64) covers saturation.
// Both share mode/read/out_ready; each has its own hit input.
module tb_multichannel_hit_histogrammer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic        rd = 1'b0;
    logic [3:0]  hit_a = 4'b0;
    logic [3:0]  hit_b = 4'b0;
    logic        out_ready = 1'b0;

    logic        va, vb;
    logic [11:0] da;
    logic [3:0]  db;
    logic [1:0]  cha, chb;
    logic [11:0] addra, addrb;
    logic        busya, busyb, donea, doneb;
`ifdef HIST_OVERFLOW_FLAG_EN
    logic [3:0]  ovfa, ovfb;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_a [4][64];

    always #5 clk = ~clk;

    multichannel_hit_histogrammer u_a (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .read      (rd),
        .hit       (hit_a),
        .out_ready (out_ready),
        .out_valid (va),
        .out_data  (da),
        .out_ch    (cha),
        .out_addr  (addra),
        .busy      (busya),
        .done      (donea)
`ifdef HIST_OVERFLOW_FLAG_EN
       ,.ovf       (ovfa)
`endif
    );

    multichannel_hit_histogrammer #(
        .NUM_CH     (4),
        .ADDR_BITS  (12),
        .DATA_BITS  (4),
        .MEM_SIZE   (4),
        .BIN_CYCLES (64)
    ) u_b (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .read      (rd),
        .hit       (hit_b),
        .out_ready (out_ready),
        .out_valid (vb),
        .out_data  (db),
        .out_ch    (chb),
        .out_addr  (addrb),
        .busy      (busyb),
        .done      (doneb)
`ifdef HIST_OVERFLOW_FLAG_EN
       ,.ovf       (ovfb)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!(donea && doneb) && c < 3000) begin
            step();
            c++;
        end
        check(tag, 32'(donea && doneb), 1);
    endtask

    // Hit schedule for u_a, k = cycle index within TAKE (bin = k/16).
    function automatic logic [3:0] pat_a(input int v, input int k);
        if (v == 2) begin
            if (k == 34)  return 4'b0001;   // bin 2, kept
            if (k == 163) return 4'b1000;   // bin 10, discarded by abort
            return 4'b0000;
        end
        if (k == 1 || k == 3 || k == 5) return 4'b0001;
        if (k == 82)                    return 4'b0100;
        if (k == 1011)                  return 4'b1010;
        if (v == 1 && k == 15)          return 4'b0001;   // bin-end cycle of bin 0
        return 4'b0000;
    endfunction

    function automatic logic [3:0] pat_b(input int v, input int k);
        if (v == 0) return (k < 40 && (k % 2) == 1) ? 4'b0001 : 4'b0000;
        return (k == 1 || k == 3 || k == 5) ? 4'b0011 : 4'b0000;
    endfunction

    task automatic zero_all(input string tag);
        int cnt;
        mode = 3'b100;
        rd = 1'b1;
        step();
        cnt = 0;
        while (busya && cnt < 200) begin
            cnt++;
            step();
        end
        check({tag, " busy cycles"}, cnt, 64);
        check({tag, " done"}, 32'(donea), 1);
        mode = 3'b000;
        rd = 1'b0;
        step();
    endtask

    task automatic take_a(input int v, input string tag);
        mode = 3'b001;
        step();
        check({tag, " entry busy"}, 32'(busya), 1);
        for (int k = 0; k < 1024; k++) begin
            hit_a = pat_a(v, k);
            if (v == 2 && k == 165) begin
                hit_a = 4'b0;
                mode = 3'b000;
                step();
                check({tag, " abort busy"}, 32'(busya), 0);
                return;
            end
            if (k == 1023) check({tag, " last busy"}, 32'(busya), 1);
            step();
        end
        hit_a = 4'b0;
        check({tag, " done"}, 32'(donea), 1);
        mode = 3'b000;
        step();
        check({tag, " idle"}, {busya, donea}, 0);
    endtask

    task automatic read_a(input bit rand_rdy, input string tag);
        int words, c, first;
        bit rdy, prev_stall;
        logic [26:0] prev;
        words = 0;
        c = 0;
        first = -1;
        prev_stall = 1'b0;
        prev = '0;
        mode = 3'b010;
        rd = 1'b1;
        out_ready = 1'b0;
        step();
        while (words < 256 && c < 3000) begin
            if (prev_stall) check({tag, " hold"}, {va, cha, addra, da}, prev);
            if (va && first < 0) first = c;
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (va && rdy) begin
                check({tag, " pos"}, {cha, addra}, (words % 4) * 4096 + words / 4);
                check({tag, " data"}, da, exp_a[words % 4][words / 4]);
                words++;
            end
            prev_stall = va && !rdy;
            prev = {va, cha, addra, da};
            step();
            c++;
        end
        check({tag, " words"}, words, 256);
        check({tag, " first latency"}, first, 1);
        check({tag, " end valid"}, 32'(va), 0);
        check({tag, " end done"}, 32'(donea), 1);
        out_ready = 1'b0;
        mode = 3'b000;
        rd = 1'b0;
        step();
        check({tag, " back idle"}, 32'(donea), 0);
    endtask

    task automatic take_b(input int v, input string tag);
        mode = 3'b001;
        step();
        for (int k = 0; k < 256; k++) begin
            hit_b = pat_b(v, k);
            step();
        end
        hit_b = 4'b0;
        check({tag, " b done"}, 32'(doneb), 1);
        wait_done({tag, " both done"});
`ifdef HIST_OVERFLOW_FLAG_EN
        check({tag, " ovf b"}, ovfb, 4'b0001);
        check({tag, " ovf a"}, ovfa, 4'b0000);
`endif
        mode = 3'b000;
        step();
    endtask

    initial begin
        int n, c;
        for (int ch = 0; ch < 4; ch++)
            for (int a = 0; a < 64; a++)
                exp_a[ch][a] = 0;

        // Reset state
        #1 rst = 1'b1;
        step();
        step();
        check("rst valid", 32'(va), 0);
        check("rst busy", 32'(busya), 0);
        check("rst done", 32'(donea), 0);
        check("rst data", da, 0);
        check("rst ch", cha, 0);
        check("rst addr", addra, 0);
        rst = 1'b0;
        step();

        // Memory clear and full readout
        zero_all("zero1");
        read_a(1'b0, "rd zero");

        // Basic take
        take_a(0, "take1");
        exp_a[0][0] = 3;
        exp_a[2][5] = 1;
        exp_a[1][63] = 1;
        exp_a[3][63] = 1;
        read_a(1'b0, "rd take1");

        // Accumulate without ZERO; bin-end edge lands in bin 1
        take_a(1, "take2");
        exp_a[0][0] = 6;
        exp_a[0][1] = 1;
        exp_a[2][5] = 2;
        exp_a[1][63] = 2;
        exp_a[3][63] = 2;
        read_a(1'b0, "rd take2");

        // Abort during bin 10, then readout under random backpressure
        take_a(2, "abort");
        exp_a[0][2] = 1;
        read_a(1'b1, "rd bp");

        // Asynchronous reset in the middle of a readout
        mode = 3'b010;
        rd = 1'b1;
        out_ready = 1'b0;
        step();
        step();
        step();
        check("pre-rst valid", 32'(va), 1);
        #2 rst = 1'b1;
        #1;
        check("async rst valid", 32'(va), 0);
        check("async rst busy", 32'(busya), 0);
        mode = 3'b000;
        rd = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("post-rst done", 32'(donea), 0);

        // Saturation on the 4-bit instance
        zero_all("zero2");
        take_b(0, "sat1");
        take_b(1, "sat2");
        mode = 3'b010;
        rd = 1'b1;
        out_ready = 1'b1;
        step();
        n = 0;
        c = 0;
        while (n < 16 && c < 200) begin
            if (vb) begin
                check("b pos", {chb, addrb}, (n % 4) * 4096 + n / 4);
                check("b data", db, (n == 0) ? 15 : (n == 1) ? 3 : 0);
                n++;
            end
            step();
            c++;
        end
        check("b words", n, 16);
        wait_done("b rd done");
        out_ready = 1'b0;
        mode = 3'b000;
        rd = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
